// File: rtl/pw_seq_pkg.sv
// rtl/pw_seq_pkg.sv - shared constants and FSM state type for the pulse-width sequencer
package pw_seq_pkg;

  localparam int W_BITS_DEF = 13;
  localparam int W_MAX_DEF  = 8191;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    LOAD,
    WAIT_DONE,
    DONE
  } pw_state_e;

endpackage

// File: rtl/pw_seq_fifo.sv
// rtl/pw_seq_fifo.sv - synchronous command FIFO with registered read data and occupancy level
module pw_seq_fifo
  import pw_seq_pkg::*;
#(
  parameter int WIDTH = W_BITS_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic             do_wr;
  logic             do_rd;

  assign full        = (level == LW'(DEPTH));
  assign empty       = (level == '0);
  assign do_wr       = wr_en & ~full;
  assign do_rd       = rd_en & ~empty;
  assign rd_ptr_next = do_rd ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Head is re-read every cycle, so a word written into an empty FIFO is visible one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_ptr_next;
      rd_data <= mem[rd_ptr_next];
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pw_width_sequencer.sv
// rtl/pw_width_sequencer.sv - frame-aligned pulse-width loader for the W decoder; PW_SEQ_TIMEOUT_EN adds a dec_done timeout
module pw_width_sequencer
  import pw_seq_pkg::*;
#(
  parameter int W_BITS     = W_BITS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int W_MIN      = 1,
  parameter int W_MAX      = W_MAX_DEF,
  parameter int RST_CYC    = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [W_BITS-1:0]             s_width,
  input  logic                          frame_tick,
  input  logic                          dec_done,
  output logic [W_BITS-1:0]             W,
  output logic                          dec_reset,
  output logic                          loaded,
  output logic                          rejected,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          err_clr,
  output logic                          timeout_err
);

  localparam int          RC_W    = $clog2(RST_CYC + 1);
  localparam logic [31:0] W_MIN_L = 32'(W_MIN);
  localparam logic [31:0] W_MAX_L = 32'(W_MAX);

  pw_state_e         state_q;
  pw_state_e         state_d;
  logic              frame_tick_q;
  logic              dec_done_q;
  logic              tick;
  logic              done_rise;
  logic [31:0]       s_width_ext;
  logic              in_range;
  logic              push_hs;
  logic              wr_en;
  logic              rd_en;
  logic              full;
  logic              empty;
  logic [W_BITS-1:0] rd_data;
  logic [RC_W-1:0]   rst_cnt_q;
  logic              rst_last;
  logic              to_expire;

  assign tick        = frame_tick & ~frame_tick_q;
  assign done_rise   = dec_done & ~dec_done_q;
  assign s_ready     = ~full;
  assign push_hs     = s_valid & s_ready;
  assign s_width_ext = 32'(s_width);
  assign in_range    = (s_width_ext >= W_MIN_L) && (s_width_ext <= W_MAX_L);
  assign wr_en       = push_hs & in_range;
  assign rst_last    = (rst_cnt_q == RC_W'(RST_CYC - 1));

  pw_seq_fifo #(
    .WIDTH (W_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (s_width),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (tick) begin
          state_d = LOAD;
          rd_en   = 1'b1;
        end
      end
      LOAD: begin
        if (rst_last) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A completing edge takes precedence over a coincident timeout.
        if (done_rise)      state_d = DONE;
        else if (to_expire) state_d = IDLE;
      end
      DONE: begin
        state_d = empty ? IDLE : WAIT_FRAME;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      frame_tick_q <= 1'b0;
      dec_done_q   <= 1'b0;
      rst_cnt_q    <= '0;
      W            <= '0;
      dec_reset    <= 1'b0;
      loaded       <= 1'b0;
      rejected     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_tick_q <= frame_tick;
      dec_done_q   <= dec_done;
      rst_cnt_q    <= (state_q == LOAD) ? rst_cnt_q + 1'b1 : '0;
      if (rd_en) begin
        W <= rd_data;
      end
      dec_reset    <= (state_d == LOAD);
      loaded       <= (state_d == DONE);
      rejected     <= push_hs & ~in_range;
      busy         <= (state_d != IDLE);
    end
  end

`ifdef PW_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q;
  logic          err_q;

  assign to_expire   = (state_q == WAIT_DONE) && (to_cnt_q == TW'(TIMEOUT - 1));
  assign timeout_err = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == WAIT_DONE) ? to_cnt_q + 1'b1 : '0;
      if (to_expire && !done_rise) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  logic [32:0] unused_cfg;

  assign unused_cfg  = {err_clr, 32'(TIMEOUT)};
  assign to_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pw_width_sequencer.sv
// tb/tb_pw_width_sequencer.sv - directed self-checking bench for pw_width_sequencer
module tb_pw_width_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [12:0] s_width;
  logic        frame_tick;
  logic        dec_done;
  logic [12:0] W;
  logic        dec_reset;
  logic        loaded;
  logic        rejected;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        err_clr;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pw_width_sequencer #(
    .W_BITS     (13),
    .FIFO_DEPTH (4),
    .W_MIN      (1),
    .W_MAX      (5000),
    .RST_CYC    (2),
    .TIMEOUT    (256)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_width     (s_width),
    .frame_tick  (frame_tick),
    .dec_done    (dec_done),
    .W           (W),
    .dec_reset   (dec_reset),
    .loaded      (loaded),
    .rejected    (rejected),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input int w);
    s_valid = 1'b1;
    s_width = 13'(w);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_loaded(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (loaded) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; s_width = '0; frame_tick = 1'b0;
    dec_done = 1'b0; err_clr = 1'b0;
    #12;
    checks++; if (W !== 13'd0) begin errors++; $display("FAIL rst_w got %0d exp 0", W); end
    checks++; if (dec_reset !== 1'b0) begin errors++; $display("FAIL rst_dec_reset got %b exp 0", dec_reset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if ({loaded, rejected, timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {loaded, rejected, timeout_err}); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_single_load();
    push(100);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t1_level got %0d exp 1", fifo_level); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_wait got %b exp 1", busy); end
    pulse_tick();
    checks++; if (dec_reset !== 1'b1 || W !== 13'd100) begin errors++; $display("FAIL t1_load got dec_reset=%b W=%0d exp 1/100", dec_reset, W); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t1_pop got %0d exp 0", fifo_level); end
    step();
    checks++; if (dec_reset !== 1'b1) begin errors++; $display("FAIL t1_rst_hold got %b exp 1", dec_reset); end
    step();
    checks++; if (dec_reset !== 1'b0) begin errors++; $display("FAIL t1_rst_end got %b exp 0", dec_reset); end
    dec_done = 1'b1;
    step();
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL t1_loaded got %b exp 1", loaded); end
    dec_done = 1'b0;
    step();
    checks++; if (loaded !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_idle got loaded=%b busy=%b exp 0/0", loaded, busy); end
    checks++; if (W !== 13'd100) begin errors++; $display("FAIL t1_w_hold got %0d exp 100", W); end
  endtask

  task automatic test_range_reject();
    int bad [3];
    bad = '{0, 5001, 8191};
    for (int i = 0; i < 3; i++) begin
      push(bad[i]);
      checks++; if (rejected !== 1'b1) begin errors++; $display("FAIL t2_rejected[%0d] got %b exp 1", i, rejected); end
    end
    step();
    checks++; if (rejected !== 1'b0) begin errors++; $display("FAIL t2_rejected_pulse got %b exp 0", rejected); end
    checks++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL t2_no_load got level=%0d busy=%b exp 0/0", fifo_level, busy); end
  endtask

  task automatic test_back_to_back();
    int vals [4];
    logic seen;
    vals = '{1, 5000, 77, 4095};
    for (int i = 0; i < 4; i++) push(vals[i]);
    checks++; if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin errors++; $display("FAIL t3_full got level=%0d s_ready=%b exp 4/0", fifo_level, s_ready); end
    push(123);
    checks++; if (fifo_level !== 3'd4 || rejected !== 1'b0) begin errors++; $display("FAIL t3_refused got level=%0d rejected=%b exp 4/0", fifo_level, rejected); end
    for (int i = 0; i < 4; i++) begin
      step();
      pulse_tick();
      checks++; if (dec_reset !== 1'b1 || W !== 13'(vals[i])) begin errors++; $display("FAIL t3_load[%0d] got dec_reset=%b W=%0d exp 1/%0d", i, dec_reset, W, vals[i]); end
      checks++; if (fifo_level !== 3'(3 - i)) begin errors++; $display("FAIL t3_level[%0d] got %0d exp %0d", i, fifo_level, 3 - i); end
      step();
      step();
      dec_done = 1'b1;
      wait_loaded(seen);
      dec_done = 1'b0;
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t3_loaded[%0d] got %b exp 1", i, seen); end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_idle got %b exp 0", busy); end
  endtask

  task automatic test_ignored_events();
    int   n_loaded;
    int   n_rst;
    logic seen;
    push(321);
    push(654);
    dec_done = 1'b1;
    step();
    pulse_tick();
    checks++; if (W !== 13'd321) begin errors++; $display("FAIL t4_w_first got %0d exp 321", W); end
    n_loaded = 0;
    n_rst = 0;
    step();
    for (int i = 0; i < 12; i++) begin
      frame_tick = ~frame_tick;
      step();
      if (loaded) n_loaded++;
      if (dec_reset) n_rst++;
    end
    frame_tick = 1'b0;
    checks++; if (n_loaded !== 0 || n_rst !== 0) begin errors++; $display("FAIL t4_ignored got loaded=%0d dec_reset=%0d exp 0/0", n_loaded, n_rst); end
    checks++; if (W !== 13'd321 || fifo_level !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL t4_hold got W=%0d level=%0d busy=%b exp 321/1/1", W, fifo_level, busy); end
    dec_done = 1'b0;
    step();
    dec_done = 1'b1;
    wait_loaded(seen);
    dec_done = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t4_loaded got %b exp 1", seen); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (W !== 13'd321 || dec_reset !== 1'b0) begin errors++; $display("FAIL t4_no_tick got W=%0d dec_reset=%b exp 321/0", W, dec_reset); end
    pulse_tick();
    checks++; if (W !== 13'd654) begin errors++; $display("FAIL t4_w_second got %0d exp 654", W); end
    step();
    step();
    dec_done = 1'b1;
    wait_loaded(seen);
    dec_done = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    push(999);
    push(888);
    step();
    pulse_tick();
    checks++; if (dec_reset !== 1'b1 || W !== 13'd999) begin errors++; $display("FAIL t5_load got dec_reset=%b W=%0d exp 1/999", dec_reset, W); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (dec_reset !== 1'b0 || W !== 13'd0) begin errors++; $display("FAIL t5_async got dec_reset=%b W=%0d exp 0/0", dec_reset, W); end
    checks++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL t5_flush got level=%0d busy=%b exp 0/0", fifo_level, busy); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t5_after got s_ready=%b busy=%b exp 1/0", s_ready, busy); end
  endtask

  task automatic test_timeout();
    int   n;
    int   n_loaded;
    logic seen;
    push(42);
    step();
    pulse_tick();
    n = 0;
    n_loaded = 0;
`ifdef PW_SEQ_TIMEOUT_EN
    while (timeout_err !== 1'b1 && n < 1000) begin
      step();
      n++;
      if (loaded) n_loaded++;
    end
    checks++; if (n !== 258) begin errors++; $display("FAIL t6_latency got %0d exp 258", n); end
    checks++; if (busy !== 1'b0 || n_loaded !== 0 || W !== 13'd42) begin errors++; $display("FAIL t6_abort got busy=%b loaded=%0d W=%0d exp 0/0/42", busy, n_loaded, W); end
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL t6_sticky got %b exp 1", timeout_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL t6_clear got %b exp 0", timeout_err); end
`else
    for (int i = 0; i < 300; i++) begin
      err_clr = (i == 100);
      step();
      if (timeout_err !== 1'b0) n++;
    end
    err_clr = 1'b0;
    checks++; if (n !== 0 || busy !== 1'b1) begin errors++; $display("FAIL t6_no_timeout got err_cycles=%0d busy=%b exp 0/1", n, busy); end
    dec_done = 1'b1;
    wait_loaded(seen);
    dec_done = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL t6_late_done got %b exp 1", seen); end
    n_loaded = 1;
`endif
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_range_reject();
    test_back_to_back();
    test_ignored_events();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
